// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types for the packet dispatcher
package switch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - wrapped round-robin search: first set mask bit after last_i, last_i itself checked last
module rr_pick #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask_i,
  input  logic [IW-1:0]    last_i,
  output logic [IW-1:0]    idx_o,
  output logic             found_o
);

  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the nearest eligible port overwrites the rest.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int i = WIDTH; i >= 1; i--) begin
      cand = IW'((int'(last_i) + i) % WIDTH);
      if (mask_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// rtl/rr_dispatcher.sv - steers packets from one stream to WIDTH ports, round-robin per packet
module rr_dispatcher
  import switch_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         out_avail,
  output logic [WIDTH-1:0]         out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  input  logic [WIDTH-1:0]         out_ready,
  output logic [$clog2(WIDTH)-1:0] sel
);

  localparam int SW = $clog2(WIDTH);

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [SW-1:0]     lg_q, lg_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  logic [SW-1:0]     pick_idx;
  logic              pick_found;
  logic              drain;
  logic              accept;

  rr_pick #(.WIDTH(WIDTH), .IW(SW)) u_pick (
    .mask_i  (out_avail),
    .last_i  (lg_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Draining and refilling in one cycle keeps the single-entry register at full rate.
  assign drain    = full_q && out_ready[sel_q];
  assign in_ready = !RST && (!full_q || drain) && (state_q == LOCK || pick_found);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lg_d    = lg_q;
    full_d  = full_q;
    data_d  = data_q;
    last_d  = last_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = in_data;
      last_d = in_last;
      if (state_q == IDLE) begin
        sel_d = pick_idx;
        lg_d  = pick_idx;
      end
      state_d = in_last ? IDLE : LOCK;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      lg_q    <= SW'(WIDTH - 1);
      full_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lg_q    <= lg_d;
      full_q  <= full_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    out_valid = '0;
    if (full_q) out_valid[sel_q] = 1'b1;
  end

  assign out_data = data_q;
  assign out_last = last_q;
  assign sel      = sel_q;

endmodule
